// File: rtl/bus_arbiter_param.sv
// N-master bus arbiter (round-robin or fixed priority); grant held until trans_done, withdrawal or watchdog.
// Latency: grant one cycle after request; no backpressure, one IDLE turnaround cycle between grants.
`timescale 1ns/1ps
module bus_arbiter_param #(
   parameter int N_MASTERS = 4,
   parameter int N_SLAVES  = 3,
   parameter int SLAVE_LEN = 2,
   parameter int RR_MODE   = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_MASTERS-1:0]             m_request,
   input  logic [N_MASTERS*SLAVE_LEN-1:0]   m_slave_sel,
   input  logic                             trans_done,
   output logic [N_MASTERS-1:0]             m_grant,
   output logic [$clog2(N_MASTERS)-1:0]     grant_idx,
   output logic [SLAVE_LEN-1:0]             slave_sel_out,
   output logic                             arbiter_busy,
   output logic                             bus_busy,
   output logic                             sel_err,
   output logic                             timeout
);

   localparam int IDX_W  = $clog2(N_MASTERS);
   localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
   localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [N_MASTERS-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]       win_q, win_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [SLAVE_LEN-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic                   sel_err_q, sel_err_d;
   logic                   timeout_q, timeout_d;

   logic [N_MASTERS-1:0]   elig;
   logic                   found;
   logic [IDX_W-1:0]       pick;
   logic [SLAVE_LEN-1:0]   pick_sel;
   logic [IDX_W-1:0]       base;
   logic [IDX_W-1:0]       cand;
   logic                   wdog_expired;
   int                     j;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         elig[i] = m_request[i] && (int'(m_slave_sel[i*SLAVE_LEN +: SLAVE_LEN]) < N_SLAVES);
      end
   end

   // Scan starts at rr_ptr in round-robin mode, at master 0 in fixed-priority mode.
   always_comb begin
      base     = (RR_MODE != 0) ? rr_ptr_q : '0;
      found    = 1'b0;
      pick     = '0;
      pick_sel = '0;
      cand     = '0;
      j        = 0;
      for (int k = 0; k < N_MASTERS; k++) begin
         j = int'(base) + k;
         if (j >= N_MASTERS) begin
            j = j - N_MASTERS;
         end
         cand = IDX_W'(j);
         if (!found && elig[cand]) begin
            found    = 1'b1;
            pick     = cand;
            pick_sel = m_slave_sel[j*SLAVE_LEN +: SLAVE_LEN];
         end
      end
   end

   assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      win_d     = win_q;
      idx_d     = idx_q;
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      wdog_d    = wdog_q;
      sel_err_d = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_GRANT;
               grant_d = ONE_HOT0 << pick;
               win_d   = pick;
               idx_d   = pick;
               sel_d   = pick_sel;
            end else if (|m_request) begin
               sel_err_d = 1'b1;
            end
         end
         S_GRANT: begin
            wdog_d = '0;
            if (!m_request[win_q]) begin
               state_d = S_RELEASE;
               grant_d = '0;
               idx_d   = '0;
            end else begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (wdog_q != WDOG_MAX) begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
            // trans_done wins over a coincident watchdog expiry.
            if (trans_done || !m_request[win_q]) begin
               state_d = S_RELEASE;
               grant_d = '0;
               idx_d   = '0;
            end else if (wdog_expired) begin
               state_d   = S_RELEASE;
               grant_d   = '0;
               idx_d     = '0;
               timeout_d = 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            if (RR_MODE != 0) begin
               rr_ptr_d = (win_q == IDX_W'(N_MASTERS - 1)) ? '0 : win_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         win_q     <= '0;
         idx_q     <= '0;
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         wdog_q    <= '0;
         sel_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         win_q     <= win_d;
         idx_q     <= idx_d;
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         wdog_q    <= wdog_d;
         sel_err_q <= sel_err_d;
         timeout_q <= timeout_d;
      end
   end

   assign m_grant       = grant_q;
   assign grant_idx     = idx_q;
   assign slave_sel_out = sel_q;
   assign arbiter_busy  = (state_q != S_IDLE);
   assign bus_busy      = (state_q == S_BUSY);
   assign sel_err       = sel_err_q;
   assign timeout       = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// Directed bench: RR arbiter with an 8-cycle watchdog plus a fixed-priority twin on shared inputs.
`timescale 1ns/1ps
module tb_bus_arbiter_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] m_request;
   logic [7:0] m_slave_sel;
   logic       trans_done;

   logic [3:0] m_grant;
   logic [1:0] grant_idx;
   logic [1:0] slave_sel_out;
   logic       arbiter_busy, bus_busy, sel_err, timeout;

   logic [3:0] fp_grant;
   logic [1:0] fp_idx;
   logic [1:0] fp_sel;
   logic       fp_abusy, fp_bbusy, fp_selerr, fp_tmo;

   typedef struct packed {
      logic [1:0] idx;
      logic [1:0] sel;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   bus_arbiter_param #(.N_MASTERS(4), .N_SLAVES(3), .SLAVE_LEN(2), .RR_MODE(1), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .m_request(m_request), .m_slave_sel(m_slave_sel),
      .trans_done(trans_done), .m_grant(m_grant), .grant_idx(grant_idx),
      .slave_sel_out(slave_sel_out), .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
      .sel_err(sel_err), .timeout(timeout)
   );

   bus_arbiter_param #(.N_MASTERS(4), .N_SLAVES(3), .SLAVE_LEN(2), .RR_MODE(0), .TIMEOUT(0)) dut_fp (
      .clk(clk), .reset(reset), .m_request(m_request), .m_slave_sel(m_slave_sel),
      .trans_done(trans_done), .m_grant(fp_grant), .grant_idx(fp_idx),
      .slave_sel_out(fp_sel), .arbiter_busy(fp_abusy), .bus_busy(fp_bbusy),
      .sel_err(fp_selerr), .timeout(fp_tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [1:0] i, input logic [1:0] s);
      exp_t e;
      e.idx = i;
      e.sel = s;
      exp_q.push_back(e);
   endtask

   // Call only at a negedge where no grant is showing.
   task automatic wait_grant(input string tag, input int exp_lat);
      int         lat;
      bit         got;
      exp_t       e;
      logic [3:0] oh;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         if (m_grant != 4'b0000) got = 1'b1;
      end
      chk({tag, "_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, "_latency"}, lat, exp_lat);
         chk({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.idx;
            chk({tag, "_grant"}, 32'(m_grant), 32'(oh));
            chk({tag, "_idx"}, 32'(grant_idx), 32'(e.idx));
            chk({tag, "_sel"}, 32'(slave_sel_out), 32'(e.sel));
         end
      end
   endtask

   // Entered at the negedge showing GRANT; trans_done lands 'hold' cycles after the grant.
   task automatic run_xfer(input int hold, input logic [1:0] sel_exp, input logic [3:0] req_after);
      @(negedge clk);
      chk("busy_enter", 32'(bus_busy), 32'd1);
      chk("busy_sel_held", 32'(slave_sel_out), 32'(sel_exp));
      repeat (hold - 2) @(negedge clk);
      trans_done = 1'b1;
      m_request  = req_after;
      @(negedge clk);
      trans_done = 1'b0;
      chk("release_grant", 32'(m_grant), 32'd0);
      chk("release_abusy", 32'(arbiter_busy), 32'd1);
      chk("release_bbusy", 32'(bus_busy), 32'd0);
      chk("release_idx", 32'(grant_idx), 32'd0);
      @(negedge clk);
      chk("idle_abusy", 32'(arbiter_busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      m_request  = 4'h0;
      trans_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   logic [1:0] rr_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0] rr_sel [4] = '{2'd1, 2'd2, 2'd0, 2'd0};

   initial begin
      reset       = 1'b1;
      m_request   = 4'h0;
      m_slave_sel = 8'h24;          // m0=0 m1=1 m2=2 m3=0
      trans_done  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(m_grant), 32'd0);
      chk("rst_idx", 32'(grant_idx), 32'd0);
      chk("rst_sel", 32'(slave_sel_out), 32'd0);
      chk("rst_abusy", 32'(arbiter_busy), 32'd0);
      chk("rst_bbusy", 32'(bus_busy), 32'd0);
      chk("rst_selerr", 32'(sel_err), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_fp_grant", 32'(fp_grant), 32'd0);
      reset = 1'b0;

      // Reset asserted mid-BUSY drops the grant without a clock edge.
      m_request = 4'b0010;
      push_exp(2'd1, 2'd1);
      wait_grant("t1_first", 1);
      @(negedge clk);
      chk("t1_busy", 32'(bus_busy), 32'd1);
      chk("t1_busy_grant", 32'(m_grant), 32'b0010);
      #2 reset = 1'b1;
      #1;
      chk("t1_async_grant", 32'(m_grant), 32'd0);
      chk("t1_async_abusy", 32'(arbiter_busy), 32'd0);
      chk("t1_async_bbusy", 32'(bus_busy), 32'd0);
      chk("t1_async_idx", 32'(grant_idx), 32'd0);
      m_request = 4'hF;
      @(negedge clk);
      reset = 1'b0;
      push_exp(2'd0, 2'd0);
      wait_grant("t1_after_rst", 1);

      // Round-robin rotation with all four requesting.
      for (int k = 0; k < 4; k++) push_exp(rr_idx[k], rr_sel[k]);
      run_xfer(3, 2'd0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         wait_grant("t2_rr", 1);
         if (k < 3) run_xfer(3, rr_sel[k], 4'hF);
      end

      // Fixed priority starves master 3; the RR twin alternates 1,3,1.
      do_reset();
      m_request = 4'b1010;
      push_exp(2'd1, 2'd1);
      push_exp(2'd3, 2'd0);
      push_exp(2'd1, 2'd1);
      for (int k = 0; k < 3; k++) begin
         wait_grant("t3_rr", 1);
         chk("t3_fp_grant", 32'(fp_grant), 32'b0010);
         chk("t3_fp_idx", 32'(fp_idx), 32'd1);
         run_xfer(3, (k == 1) ? 2'd0 : 2'd1, (k == 2) ? 4'h0 : 4'hA);
      end

      // Invalid slave select never wins and flags sel_err every IDLE cycle.
      do_reset();
      m_slave_sel = 8'h34;          // m2=3 (invalid)
      m_request   = 4'b0100;
      chk("t4_selerr_pre", 32'(sel_err), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_selerr", 32'(sel_err), 32'd1);
         chk("t4_nogrant", 32'(m_grant), 32'd0);
         chk("t4_idle", 32'(arbiter_busy), 32'd0);
      end
      m_slave_sel = 8'h14;          // m2=1
      push_exp(2'd2, 2'd1);
      wait_grant("t4_valid", 1);
      chk("t4_selerr_clr", 32'(sel_err), 32'd0);
      m_slave_sel = 8'h24;          // change during grant must not leak through
      run_xfer(3, 2'd1, 4'h0);

      // Watchdog: expiry 8 cycles into BUSY, then trans_done on the expiry cycle.
      do_reset();
      m_request = 4'b0001;
      push_exp(2'd0, 2'd0);
      wait_grant("t5_a", 1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("t5_busy", 32'(bus_busy), 32'd1);
         chk("t5_no_tmo", 32'(timeout), 32'd0);
      end
      @(negedge clk);
      chk("t5_tmo_pulse", 32'(timeout), 32'd1);
      chk("t5_tmo_grant", 32'(m_grant), 32'd0);
      chk("t5_tmo_abusy", 32'(arbiter_busy), 32'd1);
      @(negedge clk);
      chk("t5_tmo_end", 32'(timeout), 32'd0);
      chk("t5_tmo_idle", 32'(arbiter_busy), 32'd0);
      push_exp(2'd0, 2'd0);
      wait_grant("t5_b", 1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk("t5b_no_tmo", 32'(timeout), 32'd0);
      end
      @(negedge clk);
      chk("t5b_busy_last", 32'(bus_busy), 32'd1);
      trans_done = 1'b1;
      @(negedge clk);
      trans_done = 1'b0;
      chk("t5b_done_wins", 32'(timeout), 32'd0);
      chk("t5b_grant", 32'(m_grant), 32'd0);
      chk("t5b_abusy", 32'(arbiter_busy), 32'd1);
      m_request = 4'h0;

      // Withdrawal during GRANT skips BUSY and still advances rr_ptr past the winner.
      do_reset();
      m_request = 4'b0010;
      push_exp(2'd1, 2'd1);
      wait_grant("t6_pre", 1);
      run_xfer(3, 2'd1, 4'h0);
      m_request = 4'b1000;
      push_exp(2'd3, 2'd0);
      wait_grant("t6_m3", 1);
      m_request = 4'h0;
      @(negedge clk);
      chk("t6_rel_grant", 32'(m_grant), 32'd0);
      chk("t6_rel_bbusy", 32'(bus_busy), 32'd0);
      chk("t6_rel_abusy", 32'(arbiter_busy), 32'd1);
      chk("t6_rel_idx", 32'(grant_idx), 32'd0);
      m_request = 4'hF;
      @(negedge clk);
      chk("t6_idle", 32'(arbiter_busy), 32'd0);
      push_exp(2'd0, 2'd0);
      wait_grant("t6_rr_wrap", 1);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
